// File: rtl/comparador_iterativo_id_pkg.sv
// Shared definitions for the iterative comparator.
// - state_t   : controller states (IDLE, RUN)
// - EQ/GT/LT  : (m,n) encodings of the running comparison state
// - mn_to_flags : maps a final (m,n) state onto {gt, lt, eq}
package comparador_iterativo_id_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] EQ = 2'b11;
  localparam logic [1:0] GT = 2'b10;
  localparam logic [1:0] LT = 2'b01;

  // {gt, lt, eq}; 00 cannot occur, so it falls into the eq arm.
  function automatic logic [2:0] mn_to_flags(input logic [1:0] mn);
    logic [2:0] flags;
    case (mn)
      GT:      flags = 3'b100;
      LT:      flags = 3'b010;
      default: flags = 3'b001;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/comparador_iterativo_id_if.sv
// Handshake/operand bundle of the iterative comparator.
// - start, clear : requests from the master
// - a, b         : operands, sampled on an accepted start
// - ready        : comparator idle
// - done         : one-cycle result strobe
// - gt, lt, eq   : held result flags
interface comparador_iterativo_id_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (output start, clear, a, b, input ready, done, gt, lt, eq);
  modport slave  (input start, clear, a, b, output ready, done, gt, lt, eq);
endinterface

// File: rtl/comparador_iterativo_id_celda.sv
// One-bit comparison cell: advances the running (m,n) state by one bit pair.
// - m_in, n_in   : state so far (11 equal, 10 A greater, 01 A less)
// - a, b         : current bit pair
// - m_out, n_out : updated state; 10 and 01 are absorbing
module celda_comparador (
  input  logic m_in,
  input  logic n_in,
  input  logic a,
  input  logic b,
  output logic m_out,
  output logic n_out
);
  assign m_out = ~n_in | (m_in & (a | ~b));
  assign n_out = ~m_in | (n_in & (~a | b));
endmodule

// File: rtl/comparador_iterativo_id.sv
// Iterative MSB-first magnitude comparator, DIGITS bits per clock.
// - clk, rst_n : clock and asynchronous active-low reset
// - bus        : slave side of comparador_iterativo_id_if (start/clear/a/b in,
//                ready/done/gt/lt/eq out)
// Terminates early as soon as the operands are known to differ.
module comparador_iterativo_id
  import comparador_iterativo_id_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  comparador_iterativo_id_if.slave bus
);

  localparam int CHUNKS = WIDTH / DIGITS;
  localparam int CW     = $clog2(CHUNKS) + 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [1:0]       mn_reg, mn_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic [2:0]       flags_reg, flags_next;

  logic             first_chunk;
  logic             last_chunk;
  logic [DIGITS:0]  m_chain;
  logic [DIGITS:0]  n_chain;
  logic [1:0]       mn_cells;

  // Operands are shifted left every RUN cycle, so the chunk under test is
  // always the top DIGITS bits of a_reg/b_reg.
  assign first_chunk = (cnt_reg == '0);
  assign last_chunk  = (cnt_reg == CW'(CHUNKS - 1));
  assign m_chain[0]  = mn_reg[1];
  assign n_chain[0]  = mn_reg[0];
  assign mn_cells    = {m_chain[DIGITS], n_chain[DIGITS]};

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_cell
      logic bit_a;
      logic bit_b;
      if (SIGNED && gi == 0) begin : g_sign
        // Two's-complement: the sign bit weighs negatively, which is the
        // same as comparing it with the operands swapped.
        assign bit_a = first_chunk ? b_reg[WIDTH-1] : a_reg[WIDTH-1];
        assign bit_b = first_chunk ? a_reg[WIDTH-1] : b_reg[WIDTH-1];
      end else begin : g_plain
        assign bit_a = a_reg[WIDTH-1-gi];
        assign bit_b = b_reg[WIDTH-1-gi];
      end
      celda_comparador u_celda (
        .m_in  (m_chain[gi]),
        .n_in  (n_chain[gi]),
        .a     (bit_a),
        .b     (bit_b),
        .m_out (m_chain[gi+1]),
        .n_out (n_chain[gi+1])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    mn_next    = mn_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    flags_next = flags_reg;
    if (bus.clear) begin
      // Abort wins over start and over a completing chunk; result held.
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_next = RUN;
            a_next     = bus.a;
            b_next     = bus.b;
            mn_next    = EQ;
            cnt_next   = '0;
          end
        end
        RUN: begin
          a_next   = a_reg << DIGITS;
          b_next   = b_reg << DIGITS;
          mn_next  = mn_cells;
          cnt_next = cnt_reg + CW'(1);
          if (last_chunk || mn_cells != EQ) begin
            state_next = IDLE;
            done_next  = 1'b1;
            flags_next = mn_to_flags(mn_cells);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      mn_reg    <= EQ;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      flags_reg <= 3'b000;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      mn_reg    <= mn_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      flags_reg <= flags_next;
    end
  end

  assign bus.ready = (state_reg == IDLE);
  assign bus.done  = done_reg;
  assign bus.gt    = flags_reg[2];
  assign bus.lt    = flags_reg[1];
  assign bus.eq    = flags_reg[0];

endmodule
